mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter MAX_WAIT, default 15, is the maximum number of cycles to wait for mem_ack before the access is aborted.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 req_valid  in  1  pipeline MEM-stage request present.
REQ-005 req_ready  out  1  unit can accept a request this cycle.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-008 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-justified for byte and halfword.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  out  1  abort (timeout or misalign), qualified by resp_valid.
REQ-014 mem_addr  out  32  word index, equal to req_addr >> 2.
REQ-015 mem_wdata  out  32  full word to write.
REQ-016 mem_read  out  1  read strobe to data memory.
REQ-017 mem_write  out  1  write strobe to data memory.
REQ-018 mem_rdata  in  32  read word, valid when mem_ack=1 during a read.
REQ-019 mem_ack  in  1  memory completion of the current strobe.

Function
REQ-020 The FSM shall have the states IDLE, RD, WR and RESP.
REQ-021 req_ready shall be 1 only in IDLE; a request is accepted on an edge with req_valid=1 and req_ready=1, and its address, data and control are latched.
REQ-022 Accepted loads shall sequence IDLE->RD->RESP, word stores IDLE->WR->RESP, and byte and halfword stores IDLE->RD->WR->RESP as a read-modify-write.
REQ-023 mem_read shall be 1 exactly in RD and mem_write exactly in WR; all memory outputs shall be registered and held stable while their strobe is high.
REQ-024 mem_ack shall be sampled in RD and WR; the earliest ack is the first cycle of the state, and the FSM shall advance on the edge that samples ack=1.
REQ-025 Minimum accept-to-resp_valid latency shall be 2 cycles for loads and word stores and 3 cycles for sub-word stores.
REQ-026 RESP shall last exactly one cycle with resp_valid=1, then return to IDLE; no request is accepted in RESP.
REQ-027 Byte order shall be big-endian: byte offset 0 is bits 31:24 and halfword offset 0 is bits 31:16.
REQ-028 Loads shall extract the addressed lane and then zero- or sign-extend it to 32 bits per req_unsigned.
REQ-029 Sub-word stores shall replace only the addressed lane of the word read in RD with the low bits of req_wdata; the merged word shall appear on mem_wdata in WR.
REQ-030 A wait counter shall clear on entry to RD or WR; if it reaches MAX_WAIT without mem_ack, the FSM shall drop the strobe, go to RESP with resp_err=1, and issue no write for that request.
REQ-031 An ack arriving in IDLE or RESP shall be ignored.

Reset
REQ-032 With rst_n=0 at an edge: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, wait counter 0.
REQ-033 Reset asserted mid-access shall abort the access with no response pulse and no pending write; an RMW aborted in RD shall never write.

Configuration
REQ-034 With MISALIGN_TRAP_EN defined, a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 shall be accepted, shall make no memory access, and shall go IDLE->RESP with resp_err=1 and resp_rdata=0.
REQ-035 Without MISALIGN_TRAP_EN, misaligned offsets shall be forced aligned (halfword uses addr[1] only, word ignores addr[1:0]), and resp_err shall be driven only by timeout.

Verification
REQ-036 Word 5=0xA952954F, LB addr 0x14 signed -> resp_rdata=0xFFFFFFA9; the same access unsigned -> 0x000000A9; ack in first RD cycle -> resp_valid 2 cycles after accept.
REQ-037 LH addr 0x16 signed, word 5=0xA952954F -> resp_rdata=0xFFFF954F; LB addr 0x15 -> 0x00000052.
REQ-038 Word 4=0xFC000001, SB addr 0x11 with wdata 0x000000AB -> mem_read, then mem_write of 0xFCAB0001 to index 4; resp_valid 3 cycles after accept; resp_err=0.
REQ-039 With mem_ack held 0 and MAX_WAIT=15 -> strobe drops after 15 cycles, resp_valid=1 and resp_err=1; an SB aborted in RD never asserts mem_write.
REQ-040 rst_n=0 while in WR -> mem_write=0 at the next edge, no resp_valid, req_ready=1.
REQ-041 With MISALIGN_TRAP_EN, LW addr 0x0A -> no strobe, resp_valid the cycle after accept with resp_err=1; without the macro, the same request reads index 2.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline MEM stage and a single-port word memory.
// Optional build macro MISALIGN_TRAP_EN: misaligned halfword/word accesses return resp_err without touching memory.
module mem_access_unit #(
   parameter int MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [1:0]  dbg_state
);

   // Handshake: a request transfers on a rising edge where req_valid && req_ready;
   // req_ready is high only while idle. resp_valid is a single-cycle pulse per accepted request.
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] wait_cnt;
   logic             r_we;
   logic [1:0]       r_size;
   logic             r_unsigned;
   logic [1:0]       r_off;
   logic [31:0]      r_wdata;

   assign req_ready = (state == S_IDLE);
   assign dbg_state = state;

   // Big-endian lanes: offset 0 is the most significant byte/halfword.
   function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      case (off)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      h = off[1] ? w[15:0] : w[31:16];
      case (size)
         2'b00:   res = uns ? {24'h0, b} : {{24{b[7]}}, b};
         2'b01:   res = uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: res = w;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] merge_lane(input logic [31:0] w, input logic [1:0] size,
                                              input logic [1:0] off, input logic [31:0] d);
      logic [31:0] res;
      res = w;
      if (size == 2'b00) begin
         case (off)
            2'd0:    res[31:24] = d[7:0];
            2'd1:    res[23:16] = d[7:0];
            2'd2:    res[15:8]  = d[7:0];
            default: res[7:0]   = d[7:0];
         endcase
      end else if (size == 2'b01) begin
         if (off[1]) res[15:0]  = d[15:0];
         else        res[31:16] = d[15:0];
      end else begin
         res = d;
      end
      return res;
   endfunction

`ifdef MISALIGN_TRAP_EN
   logic misalign;
   assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                     (req_size[1] && (req_addr[1:0] != 2'b00));
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         wait_cnt   <= '0;
         r_we       <= 1'b0;
         r_size     <= 2'b00;
         r_unsigned <= 1'b0;
         r_off      <= 2'b00;
         r_wdata    <= '0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we       <= req_we;
                  r_size     <= req_size;
                  r_unsigned <= req_unsigned;
                  r_off      <= req_addr[1:0];
                  r_wdata    <= req_wdata;
                  mem_addr   <= {2'b00, req_addr[31:2]};
                  wait_cnt   <= '0;
`ifdef MISALIGN_TRAP_EN
                  if (misalign) begin
                     state      <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else
`endif
                  if (req_we && req_size[1]) begin
                     state     <= S_WR;
                     mem_write <= 1'b1;
                     mem_wdata <= req_wdata;
                  end else begin
                     // Loads and sub-word stores both start with a read.
                     state    <= S_RD;
                     mem_read <= 1'b1;
                  end
               end
            end
            S_RD: begin
               if (mem_ack) begin
                  mem_read <= 1'b0;
                  wait_cnt <= '0;
                  if (r_we) begin
                     state     <= S_WR;
                     mem_write <= 1'b1;
                     mem_wdata <= merge_lane(mem_rdata, r_size, r_off, r_wdata);
                  end else begin
                     state      <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b0;
                     resp_rdata <= load_extend(mem_rdata, r_size, r_off, r_unsigned);
                  end
               end else if (wait_cnt == CNT_LAST) begin
                  mem_read   <= 1'b0;
                  state      <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_WR: begin
               if (mem_ack || (wait_cnt == CNT_LAST)) begin
                  mem_write  <= 1'b0;
                  state      <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= !mem_ack;
                  resp_rdata <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: begin
               state      <= S_IDLE;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
            end
         endcase
      end
   end

endmodule
